// File: rtl/tank_pkg.sv
// Shared constants for the reservoir plant model and the controller bench:
// fault-target encoding plus default rates and thresholds.
package tank_pkg;

   localparam logic [1:0] FLT_L    = 2'd0;
   localparam logic [1:0] FLT_M    = 2'd1;
   localparam logic [1:0] FLT_H    = 2'd2;
   localparam logic [1:0] FLT_NONE = 2'd3;

   localparam int unsigned DEF_LEVEL_W    = 8;
   localparam int unsigned DEF_MAX_LEVEL  = 200;
   localparam int unsigned DEF_INIT_LEVEL = 0;
   localparam int unsigned DEF_L_TH       = 20;
   localparam int unsigned DEF_M_TH       = 100;
   localparam int unsigned DEF_H_TH       = 180;
   localparam int unsigned DEF_TICK_DIV   = 4;
   localparam int unsigned DEF_FILL_RATE  = 5;
   localparam int unsigned DEF_BS_RATE    = 3;
   localparam int unsigned DEF_VS_RATE    = 1;

endpackage

// File: rtl/tank_level_sim_if.sv
// Valve commands, fault controls and sensor/status returns between the
// irrigation controller (master) and the reservoir plant model (slave).
interface tank_level_sim_if #(
   parameter int unsigned LEVEL_W = 8
);
   logic               Ve;
   logic               Bs;
   logic               Vs;
   logic               flt_en;
   logic [1:0]         flt_sel;
   logic               flt_val;
   logic               ovf_clr;
   logic               H;
   logic               M;
   logic               L;
   logic [LEVEL_W-1:0] level;
   logic               tick;
   logic               ovf;
   logic               dry;

   modport master (
      output Ve, Bs, Vs, flt_en, flt_sel, flt_val, ovf_clr,
      input  H, M, L, level, tick, ovf, dry
   );

   modport slave (
      input  Ve, Bs, Vs, flt_en, flt_sel, flt_val, ovf_clr,
      output H, M, L, level, tick, ovf, dry
   );

endinterface

// File: rtl/tank_level_sim_tick_gen.sv
// Integration prescaler: integ_c flags the edge that integrates the level,
// tick is its registered one-cycle strobe.
module tick_gen
   import tank_pkg::*;
#(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic integ_c,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] tick_cnt;

   assign integ_c = (tick_cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         tick_cnt <= integ_c ? '0 : tick_cnt + CNT_W'(1);
         tick     <= integ_c;
      end
   end

endmodule

// File: rtl/tank_level_sim.sv
// Reservoir plant model: integrates valve commands into a saturating level
// and returns H/M/L sensor bits, with fault injection on the sensor stage.
module tank_level_sim
   import tank_pkg::*;
#(
   parameter int unsigned LEVEL_W    = DEF_LEVEL_W,
   parameter int unsigned MAX_LEVEL  = DEF_MAX_LEVEL,
   parameter int unsigned INIT_LEVEL = DEF_INIT_LEVEL,
   parameter int unsigned L_TH       = DEF_L_TH,
   parameter int unsigned M_TH       = DEF_M_TH,
   parameter int unsigned H_TH       = DEF_H_TH,
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned FILL_RATE  = DEF_FILL_RATE,
   parameter int unsigned BS_RATE    = DEF_BS_RATE,
   parameter int unsigned VS_RATE    = DEF_VS_RATE
) (
   input  logic             clk,
   input  logic             rst_n,
   tank_level_sim_if.slave  bus
);

   localparam int unsigned DW = LEVEL_W + 2;

   logic                integ_c;
   logic                tick_q;
   logic [LEVEL_W-1:0]  level_q;
   logic                ovf_q;
   logic                dry_q;
   logic                h_q, m_q, l_q;
   logic signed [DW-1:0] delta_c;
   logic signed [DW-1:0] next_c;
   logic [LEVEL_W-1:0]  level_nx_c;
   logic                ovf_set_c;
   logic                dry_set_c;
   logic                h_c, m_c, l_c;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .integ_c (integ_c),
      .tick    (tick_q)
   );

   // Net rate and clamped next level; two guard bits keep the sum exact.
   always_comb begin
      delta_c = '0;
      if (bus.Ve) delta_c = delta_c + DW'(FILL_RATE);
      if (bus.Bs) delta_c = delta_c - DW'(BS_RATE);
      if (bus.Vs) delta_c = delta_c - DW'(VS_RATE);
      next_c = $signed({2'b00, level_q}) + delta_c;
      if (next_c[DW-1])
         level_nx_c = '0;
      else if (next_c > $signed(DW'(MAX_LEVEL)))
         level_nx_c = LEVEL_W'(MAX_LEVEL);
      else
         level_nx_c = LEVEL_W'(next_c);
      ovf_set_c = integ_c & bus.Ve & (next_c > $signed(DW'(MAX_LEVEL)));
      dry_set_c = integ_c & (bus.Bs | bus.Vs) & next_c[DW-1];
   end

   // Sensor thresholds with the selected bit optionally forced.
   always_comb begin
      l_c = (level_q >= LEVEL_W'(L_TH));
      m_c = (level_q >= LEVEL_W'(M_TH));
      h_c = (level_q >= LEVEL_W'(H_TH));
      if (bus.flt_en) begin
         case (bus.flt_sel)
            FLT_L:   l_c = bus.flt_val;
            FLT_M:   m_c = bus.flt_val;
            FLT_H:   h_c = bus.flt_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_q <= LEVEL_W'(INIT_LEVEL);
         ovf_q   <= 1'b0;
         dry_q   <= 1'b0;
         h_q     <= 1'b0;
         m_q     <= 1'b0;
         l_q     <= 1'b0;
      end else begin
         if (integ_c) level_q <= level_nx_c;
         // A set on the same edge as a clear takes priority.
         ovf_q <= ovf_set_c | (ovf_q & ~bus.ovf_clr);
         dry_q <= dry_set_c | (dry_q & ~bus.ovf_clr);
         h_q   <= h_c;
         m_q   <= m_c;
         l_q   <= l_c;
      end
   end

   assign bus.level = level_q;
   assign bus.tick  = tick_q;
   assign bus.ovf   = ovf_q;
   assign bus.dry   = dry_q;
   assign bus.H     = h_q;
   assign bus.M     = m_q;
   assign bus.L     = l_q;

   param_legal_a: assert property (@(posedge clk)
      (L_TH <= M_TH) && (M_TH <= H_TH) && (H_TH <= MAX_LEVEL) &&
      (MAX_LEVEL < (2 ** LEVEL_W)) && (INIT_LEVEL <= MAX_LEVEL) && (TICK_DIV >= 1))
      else $error("tank_level_sim: illegal parameter set");

endmodule

// File: doc/tank_level_sim.md
Name: tank_level_sim

Overview:
Behavioural plant model of the irrigation reservoir, closing the loop around the irrigation controller. It consumes the controller's valve commands (inlet Ve, sprinkler Bs, drip Vs) and produces the level-sensor bits H, M and L that the controller reads. A prescaled tick integrates fill and drain rates into a saturating level counter. Fault injection forces inconsistent sensor patterns so the controller's error and alarm paths can be exercised.

Parameters:
LEVEL_W, 8, width of level counter
MAX_LEVEL, 200, full-tank level; saturation ceiling
INIT_LEVEL, 0, level loaded on reset
L_TH, 20, L sensor asserts when level >= L_TH
M_TH, 100, M sensor asserts when level >= M_TH
H_TH, 180, H sensor asserts when level >= H_TH
TICK_DIV, 4, clock cycles per integration tick (>=1)
FILL_RATE, 5, units added per tick while Ve=1
BS_RATE, 3, units removed per tick while Bs=1
VS_RATE, 1, units removed per tick while Vs=1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
Ve  in  1  inlet valve command
Bs  in  1  sprinkler pump command
Vs  in  1  drip valve command
flt_en  in  1  fault injection enable
flt_sel  in  2  fault target: 0=L, 1=M, 2=H, 3=none
flt_val  in  1  value forced onto the selected sensor
ovf_clr  in  1  clears sticky overflow/dry flags
H  out  1  high-level sensor
M  out  1  mid-level sensor
L  out  1  low-level sensor
level  out  LEVEL_W  current tank level
tick  out  1  one-cycle integration strobe
ovf  out  1  sticky: fill attempted at MAX_LEVEL
dry  out  1  sticky: drain attempted at level 0

Behaviour:
- Reset (rst_n=0 at clk edge): tick_cnt=0, level=INIT_LEVEL, H=M=L=0, tick=0, ovf=0, dry=0. Reset wins over every other input, including mid-tick.
- Prescaler: tick_cnt counts 0..TICK_DIV-1 and wraps. The tick register is 1 for exactly the cycle after tick_cnt==TICK_DIV-1, giving a period of TICK_DIV cycles. With TICK_DIV=1, tick is constantly 1 after the first post-reset cycle.
- Integration on the edge where tick_cnt==TICK_DIV-1: Ve, Bs and Vs are sampled on that edge only; they are ignored between ticks.
  - delta = (Ve?FILL_RATE:0) - (Bs?BS_RATE:0) - (Vs?VS_RATE:0), computed signed in LEVEL_W+2 bits.
  - next = level + delta, then clamped to [0, MAX_LEVEL]. The level never wraps.
- level updates on the integration edge, in the same cycle that the tick register rises.
- Sensors are registered from the updated level one cycle later: L=(level>=L_TH), M=(level>=M_TH), H=(level>=H_TH). Latency from valve sample to sensor change is therefore 2 clk edges.
- Fault override is applied in the sensor register stage:
  - When flt_en=1 and flt_sel!=3, the selected bit takes flt_val; the other bits are unaffected.
  - flt_sel=3 or flt_en=0 gives normal sensors.
  - The override takes effect on the next edge with no tick dependency. Level integration is unaffected.
- ovf is set on an integration edge where Ve=1 and the unclamped next value > MAX_LEVEL.
- dry is set on an integration edge where (Bs|Vs)=1 and the unclamped next value < 0.
- Both flags are cleared by ovf_clr=1. If set and clear occur on the same edge, set wins.
- Simultaneous fill and drain: the net delta applies, e.g. Ve=Bs=Vs=1 gives +1/tick with defaults.
- Parameter legality: L_TH <= M_TH <= H_TH <= MAX_LEVEL < 2^LEVEL_W, and INIT_LEVEL <= MAX_LEVEL. These are checked by simulation-only assertions.

Decomposition:
- Package tank_pkg holds:
  - the flt_sel encoding constants FLT_L, FLT_M, FLT_H, FLT_NONE;
  - default rate and threshold constants shared with the controller bench.
- One sub-module, tick_gen, holds the TICK_DIV prescaler and registered tick output. The level, flag and sensor logic stays in the top module.

Test Plan:
- Reset with INIT_LEVEL=0, then hold Ve=1, Bs=Vs=0 -> level steps 5 per 4 cycles; L=1 after 4th tick (level 20) +1 cycle; M=1 at level 100 (tick 20); H=1 at level 180 (tick 36).
- Fill to 200 with Ve=1 held -> level saturates at 200, never 205/wraps; ovf sets on tick 41; ovf_clr=1 clears it; ovf re-sets next tick if Ve stays 1.
- From level 10, Bs=Vs=1, Ve=0 -> level 6, 2, then 0 (clamped); L stays 0; dry=1 on third tick.
- Ve=Bs=Vs=1 from level 100 -> level 101, 102, ... per tick; Ve toggled between ticks has no effect on level.
- Level 50 (L=1, M=0, H=0), flt_en=1, flt_sel=2, flt_val=1 -> next cycle H=1, M=0, L=1 (controller error pattern); flt_sel=3 -> H=0 next cycle; level unchanged throughout.
- Assert rst_n=0 one cycle before a tick at level 150 -> next edge level=INIT_LEVEL, H=M=L=0, ovf=dry=0, tick_cnt restarts so the first tick comes TICK_DIV cycles after release.
